// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with per-entry saturating
// direction counters plus a circular return address stack. Lookup is
// combinational on the fetch PC; training comes from resolved EX outcomes.
module branch_predictor #(
  parameter int XLEN       = 32,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 8,
  parameter int CNT_BITS   = 2,
  parameter int RAS_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [1:0]      upd_kind,
  input  logic            upd_call,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);

  localparam int N      = 1 << INDEX_BITS;
  localparam int TAG_LO = INDEX_BITS + 2;
  localparam int TAG_HI = INDEX_BITS + TAG_BITS + 1;
  localparam bit RAS_ON = (RAS_DEPTH > 0);
  localparam int RD     = (RAS_DEPTH > 0) ? RAS_DEPTH : 1;
  localparam int PW     = (RD > 1) ? $clog2(RD) : 1;
  localparam int CW     = $clog2(RD + 1);

  localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CNT_WEAK = CNT_BITS'(1) << (CNT_BITS - 1);

  // BTB storage
  logic [N-1:0]          valid_q;
  logic [TAG_BITS-1:0]   tag_q  [N];
  logic [1:0]            kind_q [N];
  logic [XLEN-1:0]       tgt_q  [N];
  logic [CNT_BITS-1:0]   cnt_q  [N];

  // RAS storage
  logic [XLEN-1:0]       ras_q  [RD];
  logic [PW-1:0]         top_q;
  logic [CW-1:0]         rcnt_q;

  // Lookup side
  logic [INDEX_BITS-1:0] l_idx;
  logic [TAG_BITS-1:0]   l_tag;
  logic                  l_hit;
  logic [XLEN-1:0]       l_seq;
  logic                  ras_avail;

  // Training side
  logic [INDEX_BITS-1:0] u_idx;
  logic [TAG_BITS-1:0]   u_tag;
  logic                  u_hit;
  logic                  we_d;
  logic [1:0]            kind_d;
  logic [XLEN-1:0]       tgt_d;
  logic [CNT_BITS-1:0]   cnt_d;

  logic                  push_s;
  logic                  pop_s;
  logic                  ras_we_d;
  logic [PW-1:0]         ras_wptr_d;
  logic [PW-1:0]         top_d;
  logic [CW-1:0]         rcnt_d;
  logic [PW-1:0]         top_inc;
  logic [PW-1:0]         top_dec;
  logic [XLEN-1:0]       ret_addr;

  // PC bits that never take part in index or tag
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], if_pc[XLEN-1:TAG_HI+1],
                            upd_pc[1:0], upd_pc[XLEN-1:TAG_HI+1]};

  // Combinational lookup; reset forces the fall-through prediction
  always_comb begin
    l_idx       = if_pc[INDEX_BITS+1:2];
    l_tag       = if_pc[TAG_HI:TAG_LO];
    l_hit       = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    l_seq       = if_pc + XLEN'(4);
    ras_avail   = RAS_ON && (rcnt_q != CW'(0));
    pred_taken  = 1'b0;
    pred_target = l_seq;
    if (!reset && l_hit) begin
      case (kind_q[l_idx])
        2'd1: begin
          if (cnt_q[l_idx][CNT_BITS-1]) begin
            pred_taken  = 1'b1;
            pred_target = tgt_q[l_idx];
          end else begin
            pred_taken  = 1'b0;
          end
        end
        2'd2: begin
          pred_taken  = 1'b1;
          pred_target = tgt_q[l_idx];
        end
        2'd3: begin
          pred_taken  = 1'b1;
          pred_target = ras_avail ? ras_q[top_q] : tgt_q[l_idx];
        end
        default: pred_taken = 1'b0;
      endcase
    end else begin
      pred_taken = 1'b0;
    end
  end

  // BTB training decision: which entry contents to write, if any
  always_comb begin
    u_idx  = upd_pc[INDEX_BITS+1:2];
    u_tag  = upd_pc[TAG_HI:TAG_LO];
    u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    we_d   = 1'b0;
    kind_d = upd_kind;
    tgt_d  = upd_target;
    cnt_d  = cnt_q[u_idx];
    if (upd_valid) begin
      case (upd_kind)
        2'd1: begin
          if (u_hit) begin
            we_d   = 1'b1;
            kind_d = 2'd1;
            if (upd_taken) begin
              tgt_d = upd_target;
              cnt_d = (cnt_q[u_idx] == CNT_MAX) ? CNT_MAX : cnt_q[u_idx] + CNT_BITS'(1);
            end else begin
              tgt_d = tgt_q[u_idx];
              cnt_d = (cnt_q[u_idx] == CNT_BITS'(0)) ? CNT_BITS'(0) : cnt_q[u_idx] - CNT_BITS'(1);
            end
          end else if (upd_taken) begin
            we_d  = 1'b1;
            cnt_d = CNT_WEAK;
          end else begin
            we_d  = 1'b0;
          end
        end
        2'd2, 2'd3: begin
          we_d  = 1'b1;
          cnt_d = CNT_MAX;
        end
        default: we_d = 1'b0;
      endcase
    end else begin
      we_d = 1'b0;
    end
  end

  // BTB state: reset clears valid bits and counters, otherwise write one entry
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (we_d) begin
      valid_q[u_idx] <= 1'b1;
      tag_q[u_idx]   <= u_tag;
      kind_q[u_idx]  <= kind_d;
      tgt_q[u_idx]   <= tgt_d;
      cnt_q[u_idx]   <= cnt_d;
    end
  end

  // RAS next state: push advances, pop retreats, both replaces the top
  always_comb begin
    push_s     = RAS_ON && upd_valid && upd_call;
    pop_s      = RAS_ON && upd_valid && (upd_kind == 2'd3);
    ret_addr   = upd_pc + XLEN'(4);
    top_inc    = (top_q == PW'(RD - 1)) ? PW'(0) : top_q + PW'(1);
    top_dec    = (top_q == PW'(0)) ? PW'(RD - 1) : top_q - PW'(1);
    ras_we_d   = 1'b0;
    ras_wptr_d = top_q;
    top_d      = top_q;
    rcnt_d     = rcnt_q;
    if (push_s && pop_s) begin
      ras_we_d = 1'b1;
      rcnt_d   = (rcnt_q == CW'(0)) ? CW'(1) : rcnt_q;
    end else if (push_s) begin
      ras_we_d   = 1'b1;
      ras_wptr_d = top_inc;
      top_d      = top_inc;
      rcnt_d     = (rcnt_q == CW'(RD)) ? rcnt_q : rcnt_q + CW'(1);
    end else if (pop_s && (rcnt_q != CW'(0))) begin
      top_d  = top_dec;
      rcnt_d = rcnt_q - CW'(1);
    end else begin
      ras_we_d = 1'b0;
    end
  end

  // RAS state: pointer, occupancy and the written slot
  always_ff @(posedge clk) begin
    if (reset) begin
      top_q  <= '0;
      rcnt_q <= '0;
      for (int i = 0; i < RD; i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      top_q  <= top_d;
      rcnt_q <= rcnt_d;
      if (ras_we_d) begin
        ras_q[ras_wptr_d] <= ret_addr;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: hand-computed predictions after
// reset, training, hysteresis, aliasing, RAS push/pop and mid-run reset.
module tb_branch_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [1:0]  upd_kind;
  logic        upd_call;
  logic        upd_taken;
  logic [31:0] upd_target;

  int vectors = 0;
  int errors  = 0;

  branch_predictor dut (
    .clk        (clk),
    .reset      (reset),
    .if_pc      (if_pc),
    .pred_taken (pred_taken),
    .pred_target(pred_target),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_kind   (upd_kind),
    .upd_call   (upd_call),
    .upd_taken  (upd_taken),
    .upd_target (upd_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_upd();
    upd_valid  = 1'b0;
    upd_pc     = 32'h0;
    upd_kind   = 2'd0;
    upd_call   = 1'b0;
    upd_taken  = 1'b0;
    upd_target = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic [1:0] kind,
                           input logic call, input logic taken,
                           input logic [31:0] tgt);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_kind   = kind;
    upd_call   = call;
    upd_taken  = taken;
    upd_target = tgt;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [1:0] kind,
                     input logic call, input logic taken,
                     input logic [31:0] tgt);
    drive_upd(pc, kind, call, taken, tgt);
    tick();
    clear_upd();
  endtask

  task automatic look(input logic [31:0] pc);
    if_pc = pc;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_upd();
    look(32'h100);
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      errors++;
      $display("FAIL reset_hold: got %b/%h want 0/00000104", pred_taken, pred_target);
    end
    tick();
    tick();
    reset = 1'b0;
    look(32'h100);
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      errors++;
      $display("FAIL reset_after: got %b/%h want 0/00000104", pred_taken, pred_target);
    end
  endtask

  task automatic test_basic();
    drive_upd(32'h100, 2'd1, 1'b0, 1'b1, 32'h80);
    look(32'h100);
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      errors++;
      $display("FAIL no_bypass: got %b/%h want 0/00000104", pred_taken, pred_target);
    end
    tick();
    clear_upd();
    look(32'h100);
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
      errors++;
      $display("FAIL alloc_taken: got %b/%h want 1/00000080", pred_taken, pred_target);
    end
  endtask

  task automatic test_hysteresis();
    upd(32'h100, 2'd1, 1'b0, 1'b0, 32'h80);
    look(32'h100);
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      errors++;
      $display("FAIL hyst_nt1: got %b/%h want 0/00000104", pred_taken, pred_target);
    end
    upd(32'h100, 2'd1, 1'b0, 1'b0, 32'h80);
    upd(32'h100, 2'd1, 1'b0, 1'b1, 32'h80);
    look(32'h100);
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      errors++;
      $display("FAIL hyst_cnt1: got %b/%h want 0/00000104", pred_taken, pred_target);
    end
    upd(32'h100, 2'd1, 1'b0, 1'b1, 32'h80);
    look(32'h100);
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
      errors++;
      $display("FAIL hyst_cnt2: got %b/%h want 1/00000080", pred_taken, pred_target);
    end
    for (int i = 0; i < 8; i++) begin
      upd(32'h100, 2'd1, 1'b0, 1'b1, 32'h80);
    end
    upd(32'h100, 2'd1, 1'b0, 1'b0, 32'h123);
    look(32'h100);
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
      errors++;
      $display("FAIL hyst_sat: got %b/%h want 1/00000080", pred_taken, pred_target);
    end
    upd(32'h500, 2'd1, 1'b0, 1'b0, 32'h900);
    look(32'h500);
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h504) begin
      errors++;
      $display("FAIL miss_nt_noalloc: got %b/%h want 0/00000504", pred_taken, pred_target);
    end
  endtask

  task automatic test_alias();
    upd(32'h200, 2'd2, 1'b0, 1'b0, 32'h40);
    look(32'h100);
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      errors++;
      $display("FAIL alias_old: got %b/%h want 0/00000104", pred_taken, pred_target);
    end
    look(32'h200);
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h40) begin
      errors++;
      $display("FAIL alias_new: got %b/%h want 1/00000040", pred_taken, pred_target);
    end
  endtask

  task automatic test_ras();
    logic [31:0] exp_tgt [5];
    exp_tgt[0] = 32'h44;
    exp_tgt[1] = 32'h34;
    exp_tgt[2] = 32'h24;
    exp_tgt[3] = 32'h999;
    exp_tgt[4] = 32'h999;
    do_reset();
    upd(32'h300, 2'd3, 1'b0, 1'b0, 32'h999);
    look(32'h300);
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h999) begin
      errors++;
      $display("FAIL ras_empty_ret: got %b/%h want 1/00000999", pred_taken, pred_target);
    end
    for (int i = 1; i <= 5; i++) begin
      upd(32'h10 * i, 2'd0, 1'b1, 1'b0, 32'h0);
    end
    look(32'h300);
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h54) begin
      errors++;
      $display("FAIL ras_top: got %b/%h want 1/00000054", pred_taken, pred_target);
    end
    for (int i = 0; i < 5; i++) begin
      upd(32'h300, 2'd3, 1'b0, 1'b0, 32'h999);
      look(32'h300);
      vectors++;
      if (pred_taken !== 1'b1 || pred_target !== exp_tgt[i]) begin
        errors++;
        $display("FAIL ras_pop%0d: got %b/%h want 1/%h", i, pred_taken, pred_target, exp_tgt[i]);
      end
    end
  endtask

  task automatic test_push_pop();
    upd(32'h60, 2'd3, 1'b1, 1'b0, 32'h700);
    look(32'h300);
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h64) begin
      errors++;
      $display("FAIL pushpop_top: got %b/%h want 1/00000064", pred_taken, pred_target);
    end
    look(32'h60);
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h64) begin
      errors++;
      $display("FAIL pushpop_self: got %b/%h want 1/00000064", pred_taken, pred_target);
    end
    upd(32'h300, 2'd3, 1'b0, 1'b0, 32'h999);
    look(32'h300);
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h999) begin
      errors++;
      $display("FAIL pushpop_count1: got %b/%h want 1/00000999", pred_taken, pred_target);
    end
  endtask

  task automatic test_reset_mid();
    upd(32'h100, 2'd1, 1'b0, 1'b1, 32'h80);
    look(32'h100);
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
      errors++;
      $display("FAIL mid_pretrain: got %b/%h want 1/00000080", pred_taken, pred_target);
    end
    reset = 1'b1;
    drive_upd(32'h400, 2'd1, 1'b1, 1'b1, 32'h88);
    look(32'h100);
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      errors++;
      $display("FAIL mid_during: got %b/%h want 0/00000104", pred_taken, pred_target);
    end
    tick();
    reset = 1'b0;
    clear_upd();
    look(32'h100);
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      errors++;
      $display("FAIL mid_old_gone: got %b/%h want 0/00000104", pred_taken, pred_target);
    end
    look(32'h400);
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h404) begin
      errors++;
      $display("FAIL mid_upd_dropped: got %b/%h want 0/00000404", pred_taken, pred_target);
    end
    look(32'h300);
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h304) begin
      errors++;
      $display("FAIL mid_ret_gone: got %b/%h want 0/00000304", pred_taken, pred_target);
    end
  endtask

  task automatic test_wrap();
    look(32'hFFFF_FFFC);
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
      errors++;
      $display("FAIL pc_wrap: got %b/%h want 0/00000000", pred_taken, pred_target);
    end
  endtask

  initial begin
    reset = 1'b1;
    if_pc = 32'h0;
    clear_upd();
    #1;
    test_reset();
    test_basic();
    test_hysteresis();
    test_alias();
    test_ras();
    test_push_pop();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
